// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap/CSR sequencer: CSR addresses, mstatus fields,
// interrupt cause codes, core CSR op encoding and sequencer states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_STATUS,
    ST_REDIRECT,
    ST_MRET_STATUS,
    ST_MRET_EPC
  } seq_state_e;

endpackage

// File: rtl/csr_irq_prio_enc.sv
// Fixed-priority machine interrupt encoder: pending & enable -> {valid, cause code}.
// Order is MEI > MSI > MTI.
module csr_irq_prio_enc
  import csr_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [2:0] enable,
  output logic       valid,
  output logic [3:0] code
);

  logic [2:0] act;

  // bit 2 = external, bit 1 = timer, bit 0 = software
  always_comb begin
    act   = pending & enable;
    valid = |act;
    code  = 4'd0;
    if (act[2])      code = IRQ_CODE_MEI;
    else if (act[0]) code = IRQ_CODE_MSI;
    else if (act[1]) code = IRQ_CODE_MTI;
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Sole master of the M-mode CSR file port: arbitrates trap entry, MRET and core CSR instructions.
// Define CSR_VECTORED_IRQ_EN to honour vectored mtvec mode for interrupts.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  output logic              exc_ready,
  input  logic [XLEN-1:0]   exc_cause,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [2:0]        irq_pending,
  input  logic [XLEN-1:0]   irq_pc,
  input  logic              mstatus_mie,
  input  logic [2:0]        mie_bits,
  input  logic              mret_valid,
  output logic              mret_ready,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_req_op,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [XLEN-1:0]   core_req_wdata,
  output logic              core_rsp_valid,
  output logic [XLEN-1:0]   core_rsp_rdata,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_we,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              trap_busy
);

  seq_state_e        state;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   cause_q;
  logic [ADDR_W-1:0] csr_addr_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic              irq_valid;
  logic [3:0]        irq_code;
  logic              idle, irq_win;
  logic              take_exc, take_irq, take_mret, take_core;
  csr_op_e           op;
  logic              core_we;
  logic [XLEN-1:0]   core_new;
  logic [XLEN-1:0]   trap_target;

  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  csr_irq_prio_enc u_irq_prio (
    .pending (irq_pending),
    .enable  (mie_bits),
    .valid   (irq_valid),
    .code    (irq_code)
  );

  // Single-winner arbitration; nothing is accepted while reset is asserted.
  assign idle      = (state == ST_IDLE) && !rst;
  assign irq_win   = mstatus_mie && irq_valid;
  assign take_exc  = idle && exc_valid;
  assign take_irq  = idle && !exc_valid && irq_win;
  assign take_mret = idle && !exc_valid && !irq_win && mret_valid;
  assign take_core = idle && !exc_valid && !irq_win && !mret_valid && core_req_valid;

  assign exc_ready      = take_exc;
  assign mret_ready     = take_mret;
  assign core_req_ready = take_core;
  assign trap_busy      = (state != ST_IDLE);
  assign flush          = (state == ST_SAVE_EPC);
  assign redirect_valid = (state == ST_REDIRECT) || (state == ST_MRET_EPC);

  assign op      = csr_op_e'(core_req_op);
  assign core_we = (op != OP_READ) &&
                   !(((op == OP_RS) || (op == OP_RC)) && (core_req_wdata == '0));

  always_comb begin
    case (op)
      OP_RW:   core_new = core_req_wdata;
      OP_RS:   core_new = csr_rdata | core_req_wdata;
      OP_RC:   core_new = csr_rdata & ~core_req_wdata;
      default: core_new = csr_rdata;
    endcase
  end

  always_comb begin
    trap_target = {csr_rdata[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_IRQ_EN
    if (cause_q[XLEN-1] && (csr_rdata[1:0] == 2'b01))
      trap_target = {csr_rdata[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
`endif
  end

  // CSR port drive: core access in the accept cycle, otherwise one access per sequence state
  always_comb begin
    csr_addr    = csr_addr_q;
    csr_we      = 1'b0;
    csr_wdata   = '0;
    redirect_pc = redirect_pc_q;
    unique case (state)
      ST_IDLE: begin
        if (take_core) begin
          csr_addr  = core_req_addr;
          csr_we    = core_we;
          csr_wdata = core_new;
        end
      end
      ST_SAVE_EPC: begin
        csr_addr  = ADDR_W'(CSR_MEPC);
        csr_we    = 1'b1;
        csr_wdata = pc_q & ~XLEN'(3);
      end
      ST_SAVE_CAUSE: begin
        csr_addr  = ADDR_W'(CSR_MCAUSE);
        csr_we    = 1'b1;
        csr_wdata = cause_q;
      end
      ST_SAVE_STATUS: begin
        csr_addr  = ADDR_W'(CSR_MSTATUS);
        csr_we    = 1'b1;
        csr_wdata = trap_status(csr_rdata);
      end
      ST_REDIRECT: begin
        csr_addr    = ADDR_W'(CSR_MTVEC);
        redirect_pc = trap_target;
      end
      ST_MRET_STATUS: begin
        csr_addr  = ADDR_W'(CSR_MSTATUS);
        csr_we    = 1'b1;
        csr_wdata = mret_status(csr_rdata);
      end
      ST_MRET_EPC: begin
        csr_addr    = ADDR_W'(CSR_MEPC);
        redirect_pc = csr_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      csr_addr_q     <= '0;
      redirect_pc_q  <= '0;
      core_rsp_valid <= 1'b0;
      core_rsp_rdata <= '0;
    end else begin
      csr_addr_q     <= csr_addr;
      core_rsp_valid <= take_core;
      if (take_core)      core_rsp_rdata <= csr_rdata;
      if (redirect_valid) redirect_pc_q  <= redirect_pc;
      unique case (state)
        ST_IDLE: begin
          if (take_exc || take_irq) state <= ST_SAVE_EPC;
          else if (take_mret)       state <= ST_MRET_STATUS;
        end
        ST_SAVE_EPC:    state <= ST_SAVE_CAUSE;
        ST_SAVE_CAUSE:  state <= ST_SAVE_STATUS;
        ST_SAVE_STATUS: state <= ST_REDIRECT;
        ST_REDIRECT:    state <= ST_IDLE;
        ST_MRET_STATUS: state <= ST_MRET_EPC;
        ST_MRET_EPC:    state <= ST_IDLE;
        default:        state <= ST_IDLE;
      endcase
    end
  end

  // Trap context is captured once at accept and never re-read from the requester
  always_ff @(posedge clk) begin
    if (take_exc) begin
      pc_q    <= exc_pc;
      cause_q <= exc_cause;
    end else if (take_irq) begin
      pc_q    <= irq_pc;
      cause_q <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer: table-driven core CSR accesses with a response
// scoreboard, plus hand-written trap, interrupt, MRET and reset-abort sequences.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic        exc_ready;
  logic [31:0] exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [2:0]  irq_pending = '0;
  logic [31:0] irq_pc = '0;
  logic        mstatus_mie = 1'b0;
  logic [2:0]  mie_bits = '0;
  logic        mret_valid = 1'b0;
  logic        mret_ready;
  logic        core_req_valid = 1'b0;
  logic        core_req_ready;
  logic [1:0]  core_req_op = '0;
  logic [11:0] core_req_addr = '0;
  logic [31:0] core_req_wdata = '0;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_rdata;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        trap_busy;

  logic [31:0] mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] rsp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] old;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] nv;
  } vec_t;
  vec_t vecs[8];

  csr_trap_sequencer dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .irq_pending(irq_pending), .irq_pc(irq_pc), .mstatus_mie(mstatus_mie), .mie_bits(mie_bits),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_op(core_req_op),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  // CSR file model: combinational read, write on clock; bd_* is a bench backdoor preload
  assign csr_rdata = mem[csr_addr];
  always @(posedge clk) begin
    if (bd_we)       mem[bd_addr] <= bd_data;
    else if (csr_we) mem[csr_addr] <= csr_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && core_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_rsp_unexpected: got %h, required no response", core_rsp_rdata);
      end else begin
        chk("core_rsp_rdata", core_rsp_rdata, rsp_q.pop_front());
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Walks the four cycles after a trap accept; caller has already dropped the request.
  task automatic trap_walk(input logic [31:0] exp_redirect);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("trap_busy", trap_busy, 1);
      chk("core_req_ready_stall", core_req_ready, 0);
      chk("flush", flush, k == 1);
      chk("redirect_valid", redirect_valid, k == 4);
      if (k == 4) chk("redirect_pc", redirect_pc, exp_redirect);
      @(posedge clk); #1;
    end
  endtask

  task automatic irq_trap(input logic [2:0] pend, input logic [31:0] exp_cause);
    logic [31:0] exp_pc;
    poke(12'h300, 32'h0000_0008);
    poke(12'h305, 32'h8000_0101);
    exp_pc = 32'h8000_0100;
`ifdef CSR_VECTORED_IRQ_EN
    exp_pc = exp_pc + 4 * exp_cause[3:0];
`endif
    mstatus_mie = 1'b1; mie_bits = 3'b111; irq_pending = pend; irq_pc = 32'h8000_0202;
    @(negedge clk);
    chk("irq_accept_not_busy", trap_busy, 0);
    @(posedge clk); #1;
    irq_pending = '0; mstatus_mie = 1'b0; irq_pc = '0;
    trap_walk(exp_pc);
    chk("irq_mepc", mem[12'h341], 32'h8000_0200);
    chk("irq_mcause", mem[12'h342], exp_cause);
    chk("irq_mstatus", mem[12'h300], 32'h0000_1880);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b10, 12'h340, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF};
    vecs[1] = '{2'b10, 12'h340, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_0012};
    vecs[2] = '{2'b00, 12'h305, 32'h8000_0100, 32'h0000_FFFF, 1'b0, 32'h8000_0100};
    vecs[3] = '{2'b01, 12'h341, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{2'b11, 12'h340, 32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_00F0};
    vecs[5] = '{2'b11, 12'h340, 32'h0000_00AB, 32'h0000_0000, 1'b0, 32'h0000_00AB};
    vecs[6] = '{2'b01, 12'h7C0, 32'h0000_0000, 32'h0000_0055, 1'b1, 32'h0000_0055};
    vecs[7] = '{2'b01, 12'h340, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};

    // Reset: a pending exception must not be acknowledged while rst is high
    exc_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_exc_ready", exc_ready, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_csr_addr", csr_addr, 0);
    chk("rst_core_rsp_valid", core_rsp_valid, 0);
    chk("rst_core_rsp_rdata", core_rsp_rdata, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_trap_busy", trap_busy, 0);
    @(posedge clk); #1;
    exc_valid = 1'b0;
    rst = 1'b0;

    // Core accesses, with interrupts pending but globally disabled
    irq_pending = 3'b111; mie_bits = 3'b111; mstatus_mie = 1'b0;
    for (int i = 0; i < 8; i++) begin
      poke(vecs[i].addr, vecs[i].old);
      core_req_valid = 1'b1; core_req_op = vecs[i].op;
      core_req_addr = vecs[i].addr; core_req_wdata = vecs[i].wdata;
      @(negedge clk);
      chk("core_req_ready", core_req_ready, 1);
      chk("core_csr_addr", csr_addr, vecs[i].addr);
      chk("core_csr_we", csr_we, vecs[i].we);
      if (vecs[i].we) chk("core_csr_wdata", csr_wdata, vecs[i].nv);
      rsp_q.push_back(vecs[i].old);
      @(posedge clk); #1;
      core_req_valid = 1'b0;
      chk("core_csr_file", mem[vecs[i].addr], vecs[i].we ? vecs[i].nv : vecs[i].old);
    end
    irq_pending = '0; mie_bits = '0;

    // Exception colliding with a core request: exception wins, core stalls until IDLE
    poke(12'h300, 32'h0000_0008);
    poke(12'h305, 32'h8000_0100);
    poke(12'h341, 32'h0000_0000);
    poke(12'h342, 32'h0000_0000);
    exc_valid = 1'b1; exc_cause = 32'd2; exc_pc = 32'h8000_0044;
    core_req_valid = 1'b1; core_req_op = 2'b00; core_req_addr = 12'h341; core_req_wdata = '0;
    @(negedge clk);
    chk("exc_ready", exc_ready, 1);
    chk("exc_core_req_ready", core_req_ready, 0);
    @(posedge clk); #1;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
    trap_walk(32'h8000_0100);
    @(negedge clk);
    chk("post_trap_core_ready", core_req_ready, 1);
    chk("post_trap_busy", trap_busy, 0);
    rsp_q.push_back(32'h8000_0044);
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    chk("exc_mepc", mem[12'h341], 32'h8000_0044);
    chk("exc_mcause", mem[12'h342], 32'h0000_0002);
    chk("exc_mstatus", mem[12'h300], 32'h0000_1880);

    // Interrupts: priority MEI > MSI > MTI, irq dropped right after accept
    irq_trap(3'b110, 32'h8000_000B);
    irq_trap(3'b011, 32'h8000_0003);
    irq_trap(3'b010, 32'h8000_0007);

    // MRET
    poke(12'h300, 32'h0000_1880);
    poke(12'h341, 32'h8000_0048);
    mret_valid = 1'b1;
    @(negedge clk);
    chk("mret_ready", mret_ready, 1);
    @(posedge clk); #1;
    mret_valid = 1'b0;
    @(negedge clk);
    chk("mret_busy", trap_busy, 1);
    chk("mret_redirect_early", redirect_valid, 0);
    chk("mret_ready_pulse", mret_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mret_redirect_valid", redirect_valid, 1);
    chk("mret_redirect_pc", redirect_pc, 32'h8000_0048);
    chk("mret_flush", flush, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mret_done", trap_busy, 0);
    chk("mret_mstatus", mem[12'h300], 32'h0000_1888);

    // Reset during SAVE_CAUSE aborts the trap with no redirect
    poke(12'h300, 32'h0000_0008);
    poke(12'h342, 32'h0000_0077);
    exc_valid = 1'b1; exc_cause = 32'd5; exc_pc = 32'h8000_0300;
    @(posedge clk); #1;
    exc_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_csr_addr_mcause", csr_addr, 32'h342);
    rst = 1'b1;
    #1;
    chk("abort_busy", trap_busy, 0);
    chk("abort_csr_we", csr_we, 0);
    chk("abort_csr_addr", csr_addr, 0);
    chk("abort_redirect_pc", redirect_pc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_redirect", redirect_valid, 0);
    end
    chk("abort_mcause_kept", mem[12'h342], 32'h0000_0077);
    chk("abort_mstatus_kept", mem[12'h300], 32'h0000_0008);

    chk("rsp_queue_empty", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
